// File: rtl/pipe_control_unit.sv
// Pipelined RISC-V control unit: combinational decode in D, control registers
// carried through E, M and W, branch resolution and a sticky illegal-op flag.
module pipe_control_unit #(
  parameter int ALUCTRL_W = 4,
  parameter bit EN_UPPER  = 1'b1,
  parameter bit EN_JALR   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [2:0]           ImmSrcD,
  output logic                 IllegalD,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 ALUSrcE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 JalrE,
  output logic                 AuipcE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 PCSrcE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic [1:0]           ResultSrcM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic                 IllegalSeen
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                         ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
                         ALU_SRA = 4'd9;

  typedef struct packed {
    logic                 regw;
    logic                 memw;
    logic                 alusrc;
    logic                 jump;
    logic                 branch;
    logic                 jalr;
    logic                 auipc;
    logic [1:0]           rsrc;
    logic [ALUCTRL_W-1:0] aluc;
    logic [2:0]           f3;
    logic                 ill;
  } ctrl_t;

  ctrl_t      dec, ctl_e;
  logic [3:0] alu_d;
  logic       cond, seen_r;
  logic       regw_m, memw_m, regw_w;
  logic [1:0] rsrc_m, rsrc_w;

  // funct7b5 only selects sub for register-register ops; shifts use it for both
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7, input logic rtype);
    case (f3)
      3'b000:  alu_op = (rtype && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec      = '0;
    ImmSrcD  = 3'b000;
    IllegalD = 1'b0;
    alu_d    = ALU_ADD;
    case (op)
      7'b0000011: begin dec.regw = 1'b1; dec.alusrc = 1'b1; dec.rsrc = 2'b01; end
      7'b0100011: begin dec.memw = 1'b1; dec.alusrc = 1'b1; ImmSrcD = 3'b001; end
      7'b0110011: begin dec.regw = 1'b1; alu_d = alu_op(funct3, funct7b5, 1'b1); end
      7'b0010011: begin
        dec.regw = 1'b1; dec.alusrc = 1'b1; alu_d = alu_op(funct3, funct7b5, 1'b0);
      end
      7'b1100011: begin
        dec.branch = 1'b1; ImmSrcD = 3'b010; alu_d = ALU_SUB;
        if (funct3[2:1] == 2'b01) IllegalD = 1'b1;
      end
      7'b1101111: begin
        dec.regw = 1'b1; dec.jump = 1'b1; dec.rsrc = 2'b10; ImmSrcD = 3'b011;
      end
      7'b1100111: begin
        if (EN_JALR) begin
          dec.regw = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
          dec.alusrc = 1'b1; dec.rsrc = 2'b10;
        end else IllegalD = 1'b1;
      end
      7'b0110111: begin
        if (EN_UPPER) begin dec.regw = 1'b1; dec.rsrc = 2'b11; ImmSrcD = 3'b100; end
        else IllegalD = 1'b1;
      end
      7'b0010111: begin
        if (EN_UPPER) begin
          dec.regw = 1'b1; dec.auipc = 1'b1; dec.alusrc = 1'b1; ImmSrcD = 3'b100;
        end else IllegalD = 1'b1;
      end
      default: IllegalD = 1'b1;
    endcase
    dec.aluc = ALUCTRL_W'(alu_d);
    dec.f3   = funct3;
    // illegal ops travel as a bubble that only carries the illegal marker
    if (IllegalD) begin
      dec     = '0;
      ImmSrcD = 3'b000;
    end
    dec.ill = IllegalD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_e  <= '0;
      seen_r <= 1'b0;
      regw_m <= 1'b0;
      memw_m <= 1'b0;
      rsrc_m <= 2'b00;
      regw_w <= 1'b0;
      rsrc_w <= 2'b00;
    end else begin
      ctl_e  <= FlushE ? '0 : dec;
      seen_r <= seen_r | ctl_e.ill;
      regw_m <= ctl_e.regw;
      memw_m <= ctl_e.memw;
      rsrc_m <= ctl_e.rsrc;
      regw_w <= regw_m;
      rsrc_w <= rsrc_m;
    end
  end

  always_comb begin
    case (ctl_e.f3)
      3'b000:  cond = ZeroE;
      3'b001:  cond = ~ZeroE;
      3'b100:  cond = LtE;
      3'b101:  cond = ~LtE;
      3'b110:  cond = LtuE;
      3'b111:  cond = ~LtuE;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE      = ctl_e.jump | (ctl_e.branch & cond);
  assign RegWriteE   = ctl_e.regw;
  assign MemWriteE   = ctl_e.memw;
  assign ALUSrcE     = ctl_e.alusrc;
  assign JumpE       = ctl_e.jump;
  assign BranchE     = ctl_e.branch;
  assign JalrE       = ctl_e.jalr;
  assign AuipcE      = ctl_e.auipc;
  assign ResultSrcE  = ctl_e.rsrc;
  assign ALUControlE = ctl_e.aluc;
  assign RegWriteM   = regw_m;
  assign MemWriteM   = memw_m;
  assign ResultSrcM  = rsrc_m;
  assign RegWriteW   = regw_w;
  assign ResultSrcW  = rsrc_w;
  // flag is visible as soon as the illegal op occupies Execute, then held
  assign IllegalSeen = seen_r | ctl_e.ill;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: E-stage expectations queued at drive
// time and checked at E, M and W; second instance built with upper ops disabled.
module tb_pipe_control_unit;

  logic       clk = 1'b0, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, FlushE, ZeroE, LtE, LtuE;

  logic [2:0] ImmSrcD, nu_ImmSrcD;
  logic       IllegalD, RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, JalrE, AuipcE, PCSrcE;
  logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
  logic [3:0] ALUControlE;
  logic       RegWriteM, MemWriteM, RegWriteW, IllegalSeen;

  logic       nu_IllegalD, nu_RegWriteE, nu_MemWriteE, nu_ALUSrcE, nu_JumpE, nu_BranchE;
  logic       nu_JalrE, nu_AuipcE, nu_PCSrcE, nu_RegWriteM, nu_MemWriteM, nu_RegWriteW;
  logic       nu_IllegalSeen;
  logic [1:0] nu_ResultSrcE, nu_ResultSrcM, nu_ResultSrcW;
  logic [3:0] nu_ALUControlE;

  typedef struct packed {
    logic       regw, memw, alusrc, jump, branch, jalr, auipc;
    logic [1:0] rsrc;
    logic [3:0] aluc;
  } exp_t;

  exp_t hist[$];
  int   total = 0, bad = 0;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  pipe_control_unit dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .JumpE(JumpE), .BranchE(BranchE), .JalrE(JalrE), .AuipcE(AuipcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .IllegalSeen(IllegalSeen));

  pipe_control_unit #(.EN_UPPER(1'b0)) u_nu (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(nu_ImmSrcD), .IllegalD(nu_IllegalD), .RegWriteE(nu_RegWriteE),
    .MemWriteE(nu_MemWriteE), .ALUSrcE(nu_ALUSrcE), .JumpE(nu_JumpE), .BranchE(nu_BranchE),
    .JalrE(nu_JalrE), .AuipcE(nu_AuipcE), .ResultSrcE(nu_ResultSrcE),
    .ALUControlE(nu_ALUControlE), .PCSrcE(nu_PCSrcE), .RegWriteM(nu_RegWriteM),
    .MemWriteM(nu_MemWriteM), .ResultSrcM(nu_ResultSrcM), .RegWriteW(nu_RegWriteW),
    .ResultSrcW(nu_ResultSrcW), .IllegalSeen(nu_IllegalSeen));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic regw, memw, alusrc, jump, branch, jalr, auipc,
                              input logic [1:0] rsrc, input logic [3:0] aluc);
    exp_t e;
    e = {regw, memw, alusrc, jump, branch, jalr, auipc, rsrc, aluc};
    return e;
  endfunction

  // drive one decode slot, then check E now, M and W from earlier slots
  task automatic step(input string tag, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic fl, input exp_t e,
                      input logic ill, input logic [2:0] imm);
    exp_t obs;
    int   n;
    op = o; funct3 = f3; funct7b5 = f7; FlushE = fl;
    hist.push_back(fl ? exp_t'(0) : e);
    #1;
    chk({tag, ".IllegalD"}, 32'(IllegalD), 32'(ill));
    chk({tag, ".ImmSrcD"}, 32'(ImmSrcD), 32'(imm));
    @(posedge clk); #1;
    n   = hist.size();
    obs = {RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, JalrE, AuipcE, ResultSrcE, ALUControlE};
    chk({tag, ".E"}, 32'(obs), 32'(hist[n-1]));
    if (n >= 2)
      chk({tag, ".M"}, 32'({RegWriteM, MemWriteM, ResultSrcM}),
          32'({hist[n-2].regw, hist[n-2].memw, hist[n-2].rsrc}));
    if (n >= 3)
      chk({tag, ".W"}, 32'({RegWriteW, ResultSrcW}), 32'({hist[n-3].regw, hist[n-3].rsrc}));
    if (n > 3) void'(hist.pop_front());
  endtask

  task automatic idle(input string tag);
    step(tag, 7'b0000000, 3'b000, 1'b0, 1'b1, exp_t'(0), 1'b1, 3'b000);
  endtask

  initial begin
    exp_t z;
    z = '0;
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; FlushE = 1'b0;
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    #12;
    chk("rst.E", 32'({RegWriteE, MemWriteE, JumpE, BranchE, PCSrcE}), 32'd0);
    chk("rst.MW", 32'({RegWriteM, MemWriteM, RegWriteW}), 32'd0);
    chk("rst.seen", 32'({IllegalSeen, nu_IllegalSeen}), 32'd0);
    @(negedge clk); reset = 1'b0;

    // load flows to W with memory result select
    step("lw", OP_LW, 3'b010, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,2'b01,4'd0), 1'b0, 3'b000);
    idle("lw+1");
    idle("lw+2");

    step("beq", OP_BR, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,1,0,0,2'b00,4'd1), 1'b0, 3'b010);
    ZeroE = 1'b1; #1; chk("beq.taken", 32'(PCSrcE), 32'd1);
    ZeroE = 1'b0; #1; chk("beq.nottaken", 32'(PCSrcE), 32'd0);
    step("bne", OP_BR, 3'b001, 1'b0, 1'b0, mk(0,0,0,0,1,0,0,2'b00,4'd1), 1'b0, 3'b010);
    #1; chk("bne.taken", 32'(PCSrcE), 32'd1);
    step("bltu", OP_BR, 3'b110, 1'b0, 1'b0, mk(0,0,0,0,1,0,0,2'b00,4'd1), 1'b0, 3'b010);
    LtuE = 1'b1; #1; chk("bltu.taken", 32'(PCSrcE), 32'd1);
    LtuE = 1'b0; #1; chk("bltu.nottaken", 32'(PCSrcE), 32'd0);
    step("bge", OP_BR, 3'b101, 1'b0, 1'b0, mk(0,0,0,0,1,0,0,2'b00,4'd1), 1'b0, 3'b010);
    LtE = 1'b1; #1; chk("bge.nottaken", 32'(PCSrcE), 32'd0);
    LtE = 1'b0;

    step("sub", OP_R, 3'b000, 1'b1, 1'b0, mk(1,0,0,0,0,0,0,2'b00,4'd1), 1'b0, 3'b000);
    step("addi7", OP_I, 3'b000, 1'b1, 1'b0, mk(1,0,1,0,0,0,0,2'b00,4'd0), 1'b0, 3'b000);
    step("sra", OP_R, 3'b101, 1'b1, 1'b0, mk(1,0,0,0,0,0,0,2'b00,4'd9), 1'b0, 3'b000);
    step("srli", OP_I, 3'b101, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,2'b00,4'd8), 1'b0, 3'b000);
    step("srai", OP_I, 3'b101, 1'b1, 1'b0, mk(1,0,1,0,0,0,0,2'b00,4'd9), 1'b0, 3'b000);
    step("slli", OP_I, 3'b001, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,2'b00,4'd7), 1'b0, 3'b000);
    step("and", OP_R, 3'b111, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,2'b00,4'd2), 1'b0, 3'b000);
    step("sltu", OP_R, 3'b011, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,2'b00,4'd6), 1'b0, 3'b000);

    step("sw", OP_SW, 3'b010, 1'b0, 1'b0, mk(0,1,1,0,0,0,0,2'b00,4'd0), 1'b0, 3'b001);
    step("swflush", OP_SW, 3'b010, 1'b0, 1'b1, z, 1'b0, 3'b001);
    idle("swflush+1");

    step("jal", OP_JAL, 3'b000, 1'b0, 1'b0, mk(1,0,0,1,0,0,0,2'b10,4'd0), 1'b0, 3'b011);
    #1; chk("jal.pcsrc", 32'(PCSrcE), 32'd1);
    step("jalr", OP_JALR, 3'b000, 1'b0, 1'b0, mk(1,0,1,1,0,1,0,2'b10,4'd0), 1'b0, 3'b000);
    #1; chk("jalr.pcsrc", 32'(PCSrcE), 32'd1);

    step("lui", OP_LUI, 3'b000, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,2'b11,4'd0), 1'b0, 3'b100);
    chk("nu.lui.IllegalD", 32'(nu_IllegalD), 32'd1);
    chk("nu.lui.RegWriteE", 32'(nu_RegWriteE), 32'd0);
    chk("nu.lui.seen", 32'(nu_IllegalSeen), 32'd1);
    step("auipc", OP_AUIPC, 3'b000, 1'b0, 1'b0, mk(1,0,1,0,0,0,1,2'b00,4'd0), 1'b0, 3'b100);
    chk("nu.seen.hold", 32'(nu_IllegalSeen), 32'd1);
    chk("seen.afterflushed", 32'(IllegalSeen), 32'd0);

    step("br010", OP_BR, 3'b010, 1'b0, 1'b0, z, 1'b1, 3'b000);
    chk("br010.seen", 32'(IllegalSeen), 32'd1);
    idle("br010+1");
    chk("br010.seen.hold", 32'(IllegalSeen), 32'd1);

    // asynchronous reset with a write still in flight in M
    step("lw2", OP_LW, 3'b010, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,2'b01,4'd0), 1'b0, 3'b000);
    idle("lw2+1");
    #2; reset = 1'b1; #1;
    chk("async.RegWriteM", 32'(RegWriteM), 32'd0);
    chk("async.seen", 32'({IllegalSeen, nu_IllegalSeen}), 32'd0);
    @(negedge clk); reset = 1'b0;
    hist.delete();
    idle("post.rst");
    idle("post.rst+1");
    chk("post.rst.W", 32'(RegWriteW), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
